// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 front end: addressing modes, fetch FSM
// state encodings, reset PC default and the mode-to-length helper.
package cpu6502_pkg;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [3:0] {
      IMP  = 4'd0,
      ACC  = 4'd1,
      IMM  = 4'd2,
      ZP   = 4'd3,
      ZPX  = 4'd4,
      ZPY  = 4'd5,
      ABS  = 4'd6,
      ABSX = 4'd7,
      ABSY = 4'd8,
      IND  = 4'd9,
      INDX = 4'd10,
      INDY = 4'd11,
      REL  = 4'd12
   } addr_mode_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      OP   = 3'd1,
      LO   = 3'd2,
      HI   = 3'd3,
      HOLD = 3'd4
   } fetch_state_t;

   // Bytes occupied by an instruction using the given addressing mode.
   function automatic logic [1:0] mode_len(input addr_mode_t m);
      case (m)
         IMP, ACC:             mode_len = 2'd1;
         ABS, ABSX, ABSY, IND: mode_len = 2'd3;
         default:              mode_len = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/opcode_length_decoder.sv
// Combinational 6502 opcode classifier: addressing mode, instruction length
// and an illegal flag for opcodes outside the documented set.
module opcode_length_decoder
   import cpu6502_pkg::*;
(
   input  logic [7:0] opcode,
   output addr_mode_t mode,
   output logic [1:0] len,
   output logic       illegal
);

   logic [2:0] aaa;
   logic [2:0] bbb;
   logic [1:0] cc;

   assign aaa = opcode[7:5];
   assign bbb = opcode[4:2];
   assign cc  = opcode[1:0];

   // Field-based decode with the irregular opcodes patched in explicitly.
   always_comb begin
      mode    = IMP;
      illegal = 1'b0;
      case (cc)
         2'b01: begin
            case (bbb)
               3'b000:  mode = INDX;
               3'b001:  mode = ZP;
               3'b010:  mode = IMM;
               3'b011:  mode = ABS;
               3'b100:  mode = INDY;
               3'b101:  mode = ZPX;
               3'b110:  mode = ABSY;
               default: mode = ABSX;
            endcase
            // STA has no immediate form
            if (opcode == 8'h89) illegal = 1'b1;
         end
         2'b10: begin
            case (bbb)
               3'b000: begin
                  if (aaa == 3'b101) mode = IMM;
                  else               illegal = 1'b1;
               end
               3'b001: mode = ZP;
               // shifts/rotates use the accumulator; upper half are TXA/TAX/DEX/NOP
               3'b010: mode = (aaa < 3'b100) ? ACC : IMP;
               3'b011: mode = ABS;
               3'b101: mode = (opcode == 8'h96 || opcode == 8'hB6) ? ZPY : ZPX;
               3'b110: begin
                  if (aaa == 3'b100 || aaa == 3'b101) mode = IMP;
                  else                                illegal = 1'b1;
               end
               3'b111: begin
                  if (opcode == 8'hBE)      mode = ABSY;
                  else if (opcode == 8'h9E) illegal = 1'b1;
                  else                      mode = ABSX;
               end
               default: illegal = 1'b1;
            endcase
         end
         2'b00: begin
            case (bbb)
               3'b000: begin
                  case (aaa)
                     3'b000, 3'b010, 3'b011: mode = IMP;
                     3'b001:                 mode = ABS;
                     3'b100:                 illegal = 1'b1;
                     default:                mode = IMM;
                  endcase
               end
               3'b001: begin
                  if (aaa == 3'b000 || aaa == 3'b010 || aaa == 3'b011) illegal = 1'b1;
                  else                                                 mode = ZP;
               end
               3'b010: mode = IMP;
               3'b011: begin
                  if (aaa == 3'b000)        illegal = 1'b1;
                  else if (opcode == 8'h6C) mode = IND;
                  else                      mode = ABS;
               end
               3'b100: mode = REL;
               3'b101: begin
                  if (aaa == 3'b100 || aaa == 3'b101) mode = ZPX;
                  else                                illegal = 1'b1;
               end
               3'b110: mode = IMP;
               default: begin
                  if (opcode == 8'hBC) mode = ABSX;
                  else                 illegal = 1'b1;
               end
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) mode = IMP;
      len = mode_len(mode);
      // BRK skips a padding byte after the opcode
      if (opcode == 8'h00) len = 2'd2;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// 6502 instruction fetch: owns the PC, reads opcode plus operand bytes and
// hands one assembled instruction to the control unit via valid/ready.
module instruction_fetch_unit
   import cpu6502_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rdy,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [7:0]  ir_opcode,
   output logic [15:0] ir_operand,
   output logic [1:0]  ir_len,
   output logic [3:0]  ir_addr_mode,
   output logic        ir_illegal,
   output logic [15:0] ir_pc,
   output logic [15:0] pc_out
);

   fetch_state_t state_q;
   logic [15:0]  pc_q;
   logic [15:0]  pc_d;
   logic         mem_rd_q;
   logic         ir_valid_q;
   logic [7:0]   ir_opcode_q;
   logic [15:0]  ir_operand_q;
   logic [1:0]   ir_len_q;
   addr_mode_t   ir_mode_q;
   logic         ir_illegal_q;
   logic [15:0]  ir_pc_q;

   addr_mode_t   dec_mode;
   logic [1:0]   dec_len;
   logic         dec_illegal;

   // Decode the byte on the bus so length/mode are ready at opcode capture.
   opcode_length_decoder u_decoder (
      .opcode  (mem_rdata),
      .mode    (dec_mode),
      .len     (dec_len),
      .illegal (dec_illegal)
   );

   // Sequential PC step; 16-bit addition wraps FFFF to 0000 naturally.
   always_comb begin
      pc_d = pc_q + 16'd1;
   end

   // Fetch FSM: pc_load overrides everything, otherwise one byte per ready beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         mem_rd_q     <= 1'b0;
         ir_valid_q   <= 1'b0;
         ir_opcode_q  <= 8'h00;
         ir_operand_q <= 16'h0000;
         ir_len_q     <= 2'd1;
         ir_mode_q    <= IMP;
         ir_illegal_q <= 1'b0;
         ir_pc_q      <= RESET_PC;
      end else if (pc_load) begin
         // an accept in this cycle has already been taken by the consumer
         pc_q       <= pc_load_value;
         ir_valid_q <= 1'b0;
         state_q    <= en ? OP : IDLE;
         mem_rd_q   <= en;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_q  <= OP;
                  mem_rd_q <= 1'b1;
               end
            end
            OP: begin
               if (mem_rdy) begin
                  ir_opcode_q  <= mem_rdata;
                  ir_operand_q <= 16'h0000;
                  ir_pc_q      <= pc_q;
                  ir_len_q     <= dec_len;
                  ir_mode_q    <= dec_mode;
                  ir_illegal_q <= dec_illegal;
                  pc_q         <= pc_d;
                  if (dec_len == 2'd1) begin
                     state_q    <= HOLD;
                     mem_rd_q   <= 1'b0;
                     ir_valid_q <= 1'b1;
                  end else begin
                     state_q <= LO;
                  end
               end
            end
            LO: begin
               if (mem_rdy) begin
                  ir_operand_q[7:0] <= mem_rdata;
                  pc_q              <= pc_d;
                  if (ir_len_q == 2'd3) begin
                     state_q <= HI;
                  end else begin
                     state_q    <= HOLD;
                     mem_rd_q   <= 1'b0;
                     ir_valid_q <= 1'b1;
                  end
               end
            end
            HI: begin
               if (mem_rdy) begin
                  ir_operand_q[15:8] <= mem_rdata;
                  pc_q               <= pc_d;
                  state_q            <= HOLD;
                  mem_rd_q           <= 1'b0;
                  ir_valid_q         <= 1'b1;
               end
            end
            HOLD: begin
               if (ir_ready) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= en ? OP : IDLE;
                  mem_rd_q   <= en;
               end
            end
            default: begin
               state_q  <= IDLE;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr     = pc_q;
   assign mem_rd       = mem_rd_q;
   assign pc_out       = pc_q;
   assign ir_valid     = ir_valid_q;
   assign ir_opcode    = ir_opcode_q;
   assign ir_operand   = ir_operand_q;
   assign ir_len       = ir_len_q;
   assign ir_addr_mode = ir_mode_q;
   assign ir_illegal   = ir_illegal_q;
   assign ir_pc        = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by a randomized run compared against an opcode-table reference model.
module tb_instruction_fetch_unit;
   import cpu6502_pkg::*;

   logic        clk;
   logic        reset;
   logic        en;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_rdy;
   logic        ir_valid;
   logic        ir_ready;
   logic [7:0]  ir_opcode;
   logic [15:0] ir_operand;
   logic [1:0]  ir_len;
   logic [3:0]  ir_addr_mode;
   logic        ir_illegal;
   logic [15:0] ir_pc;
   logic [15:0] pc_out;

   logic [7:0]  mem [0:65535];
   int          checks;
   int          errors;

   assign mem_rdata = mem[mem_addr];

   instruction_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_rdata     (mem_rdata),
      .mem_rdy       (mem_rdy),
      .ir_valid      (ir_valid),
      .ir_ready      (ir_ready),
      .ir_opcode     (ir_opcode),
      .ir_operand    (ir_operand),
      .ir_len        (ir_len),
      .ir_addr_mode  (ir_addr_mode),
      .ir_illegal    (ir_illegal),
      .ir_pc         (ir_pc),
      .pc_out        (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Documented 6502 opcode table; -1 marks an undocumented opcode.
   function automatic int ref_code(input logic [7:0] op);
      case (op)
         8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9, 8'hA2, 8'hA0, 8'hC0, 8'hE0:
            ref_code = 2;
         8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5, 8'h06, 8'h26, 8'h46,
         8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6, 8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4:
            ref_code = 3;
         8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5, 8'h16, 8'h36, 8'h56,
         8'h76, 8'hD6, 8'hF6, 8'h94, 8'hB4:
            ref_code = 4;
         8'h96, 8'hB6:
            ref_code = 5;
         8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED, 8'h0E, 8'h2E, 8'h4E,
         8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE, 8'h20, 8'h2C, 8'h4C, 8'h8C, 8'hAC, 8'hCC, 8'hEC:
            ref_code = 6;
         8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'h9D, 8'hBD, 8'hDD, 8'hFD, 8'h1E, 8'h3E, 8'h5E,
         8'h7E, 8'hDE, 8'hFE, 8'hBC:
            ref_code = 7;
         8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9, 8'hBE:
            ref_code = 8;
         8'h6C:
            ref_code = 9;
         8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1:
            ref_code = 10;
         8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1:
            ref_code = 11;
         8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
            ref_code = 12;
         8'h0A, 8'h2A, 8'h4A, 8'h6A:
            ref_code = 1;
         8'h00, 8'h40, 8'h60, 8'h08, 8'h28, 8'h48, 8'h68, 8'h88, 8'hA8, 8'hC8, 8'hE8,
         8'h18, 8'h38, 8'h58, 8'h78, 8'h98, 8'hB8, 8'hD8, 8'hF8, 8'h8A, 8'hAA, 8'hCA,
         8'hEA, 8'h9A, 8'hBA:
            ref_code = 0;
         default:
            ref_code = -1;
      endcase
   endfunction

   function automatic int ref_len(input logic [7:0] op);
      int c;
      c = ref_code(op);
      if (c < 0)             ref_len = 1;
      else if (op == 8'h00)  ref_len = 2;
      else if (c == 0 || c == 1) ref_len = 1;
      else if (c == 6 || c == 7 || c == 8 || c == 9) ref_len = 3;
      else                   ref_len = 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until ir_valid is seen; n counts the cycles spent waiting.
   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (!ir_valid && n < maxc) begin
         step();
         n++;
      end
      chk("valid_timeout", 32'(ir_valid), 32'd1);
   endtask

   // Compares the presented instruction with the model's view of memory at 'at'.
   task automatic check_instr(input string tag, input logic [15:0] at);
      logic [7:0]  op;
      logic [15:0] a1;
      logic [15:0] a2;
      logic [15:0] opnd;
      int          c;
      int          n;
      op   = mem[at];
      a1   = at + 16'd1;
      a2   = at + 16'd2;
      c    = ref_code(op);
      n    = ref_len(op);
      opnd = 16'h0000;
      if (n >= 2) opnd[7:0]  = mem[a1];
      if (n == 3) opnd[15:8] = mem[a2];
      chk({tag, ".opcode"}, 32'(ir_opcode), 32'(op));
      chk({tag, ".operand"}, 32'(ir_operand), 32'(opnd));
      chk({tag, ".len"}, 32'(ir_len), 32'(n));
      chk({tag, ".mode"}, 32'(ir_addr_mode), (c < 0) ? 32'd0 : 32'(c));
      chk({tag, ".illegal"}, 32'(ir_illegal), (c < 0) ? 32'd1 : 32'd0);
      chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(at));
   endtask

   initial begin
      int          n;
      int          acc_cnt;
      logic [15:0] mpc;
      checks = 0;
      errors = 0;
      reset = 1'b1; en = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0000;
      mem_rdy = 1'b1; ir_ready = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      // ---- reset values
      #1;
      chk("rst.mem_rd", 32'(mem_rd), 32'd0);
      chk("rst.ir_valid", 32'(ir_valid), 32'd0);
      chk("rst.ir_opcode", 32'(ir_opcode), 32'd0);
      chk("rst.ir_operand", 32'(ir_operand), 32'd0);
      chk("rst.ir_len", 32'(ir_len), 32'd1);
      chk("rst.ir_mode", 32'(ir_addr_mode), 32'(IMP));
      chk("rst.ir_illegal", 32'(ir_illegal), 32'd0);
      chk("rst.ir_pc", 32'(ir_pc), 32'h0000);
      chk("rst.pc_out", 32'(pc_out), 32'h0000);
      $display("reset state checked");

      // ---- LDA #42, stall in HOLD, then illegal 02
      mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'h02;
      step();
      reset = 1'b0; en = 1'b1;
      step();
      chk("lda.op_rd", 32'(mem_rd), 32'd1);
      chk("lda.op_addr", 32'(mem_addr), 32'h0000);
      wait_valid(20, n);
      chk("lda.latency", 32'(n), 32'd2);
      chk("lda.opcode", 32'(ir_opcode), 32'hA9);
      chk("lda.operand", 32'(ir_operand), 32'h0042);
      chk("lda.len", 32'(ir_len), 32'd2);
      chk("lda.mode", 32'(ir_addr_mode), 32'(IMM));
      chk("lda.ir_pc", 32'(ir_pc), 32'h0000);
      chk("lda.pc_out", 32'(pc_out), 32'h0002);
      $display("LDA imm: opcode=%h operand=%h latency=%0d", ir_opcode, ir_operand, n);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall.valid", 32'(ir_valid), 32'd1);
         chk("stall.opcode", 32'(ir_opcode), 32'hA9);
         chk("stall.operand", 32'(ir_operand), 32'h0042);
         chk("stall.mem_rd", 32'(mem_rd), 32'd0);
         chk("stall.pc_out", 32'(pc_out), 32'h0002);
      end
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("accept.valid", 32'(ir_valid), 32'd0);
      chk("accept.mem_rd", 32'(mem_rd), 32'd1);
      chk("accept.mem_addr", 32'(mem_addr), 32'h0002);
      wait_valid(20, n);
      chk("ill.latency", 32'(n), 32'd1);
      chk("ill.len", 32'(ir_len), 32'd1);
      chk("ill.illegal", 32'(ir_illegal), 32'd1);
      chk("ill.mode", 32'(ir_addr_mode), 32'(IMP));
      chk("ill.ir_pc", 32'(ir_pc), 32'h0002);
      chk("ill.pc_out", 32'(pc_out), 32'h0003);
      $display("illegal 02: len=%0d illegal=%b pc=%h", ir_len, ir_illegal, pc_out);

      // ---- JMP abs then NOP back-to-back
      reset = 1'b1;
      mem[0] = 8'h4C; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'hEA;
      step();
      reset = 1'b0; ir_ready = 1'b1;
      step();
      wait_valid(20, n);
      chk("jmp.latency", 32'(n), 32'd3);
      chk("jmp.opcode", 32'(ir_opcode), 32'h4C);
      chk("jmp.operand", 32'(ir_operand), 32'h1234);
      chk("jmp.len", 32'(ir_len), 32'd3);
      chk("jmp.mode", 32'(ir_addr_mode), 32'(ABS));
      step();
      chk("b2b.valid_low", 32'(ir_valid), 32'd0);
      chk("b2b.mem_addr", 32'(mem_addr), 32'h0003);
      chk("b2b.mem_rd", 32'(mem_rd), 32'd1);
      wait_valid(20, n);
      chk("nop.latency", 32'(n), 32'd1);
      chk("nop.opcode", 32'(ir_opcode), 32'hEA);
      chk("nop.len", 32'(ir_len), 32'd1);
      chk("nop.mode", 32'(ir_addr_mode), 32'(IMP));
      chk("nop.pc_out", 32'(pc_out), 32'h0004);
      $display("JMP abs then NOP: pc=%h", pc_out);

      // ---- wait states in LO
      reset = 1'b1; ir_ready = 1'b0;
      mem[0] = 8'hA9; mem[1] = 8'h42;
      step();
      reset = 1'b0;
      step();
      step();
      chk("ws.lo_addr", 32'(mem_addr), 32'h0001);
      mem_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("ws.addr_held", 32'(mem_addr), 32'h0001);
         chk("ws.pc_held", 32'(pc_out), 32'h0001);
         chk("ws.no_valid", 32'(ir_valid), 32'd0);
      end
      mem_rdy = 1'b1;
      wait_valid(20, n);
      chk("ws.latency", 32'(n), 32'd1);
      chk("ws.operand", 32'(ir_operand), 32'h0042);
      $display("LDA with 2 wait states: operand=%h", ir_operand);

      // ---- pc_load during HI discards STA abs
      reset = 1'b1; ir_ready = 1'b1;
      mem[0] = 8'h8D; mem[1] = 8'h11; mem[2] = 8'h22; mem[16'h8000] = 8'hEA;
      step();
      reset = 1'b0;
      step();
      step();
      step();
      pc_load = 1'b1; pc_load_value = 16'h8000;
      step();
      pc_load = 1'b0;
      chk("load.valid", 32'(ir_valid), 32'd0);
      chk("load.mem_addr", 32'(mem_addr), 32'h8000);
      chk("load.mem_rd", 32'(mem_rd), 32'd1);
      wait_valid(20, n);
      chk("load.latency", 32'(n), 32'd1);
      chk("load.opcode", 32'(ir_opcode), 32'hEA);
      chk("load.ir_pc", 32'(ir_pc), 32'h8000);
      $display("pc_load in HI: next opcode=%h at %h", ir_opcode, ir_pc);

      // ---- pc_load with accept, LDA abs across the FFFF wrap
      mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'hCD; mem[0] = 8'hAB;
      pc_load = 1'b1; pc_load_value = 16'hFFFE;
      step();
      pc_load = 1'b0;
      chk("wrap.valid_low", 32'(ir_valid), 32'd0);
      chk("wrap.mem_addr", 32'(mem_addr), 32'hFFFE);
      wait_valid(20, n);
      chk("wrap.latency", 32'(n), 32'd3);
      chk("wrap.opcode", 32'(ir_opcode), 32'hAD);
      chk("wrap.operand", 32'(ir_operand), 32'hABCD);
      chk("wrap.ir_pc", 32'(ir_pc), 32'hFFFE);
      chk("wrap.pc_out", 32'(pc_out), 32'h0001);
      $display("wrap fetch: operand=%h pc=%h", ir_operand, pc_out);

      // ---- reset during LO, then en dropped mid-fetch
      mem[16'h0010] = 8'hA9; mem[16'h0011] = 8'h55;
      pc_load = 1'b1; pc_load_value = 16'h0010;
      step();
      pc_load = 1'b0;
      step();
      chk("rmid.in_lo", 32'(mem_addr), 32'h0011);
      reset = 1'b1;
      #1;
      chk("rmid.mem_rd", 32'(mem_rd), 32'd0);
      chk("rmid.valid", 32'(ir_valid), 32'd0);
      chk("rmid.opcode", 32'(ir_opcode), 32'd0);
      chk("rmid.len", 32'(ir_len), 32'd1);
      chk("rmid.ir_pc", 32'(ir_pc), 32'h0000);
      chk("rmid.pc_out", 32'(pc_out), 32'h0000);
      mem[0] = 8'hA9; mem[1] = 8'h77;
      ir_ready = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("rmid.first_addr", 32'(mem_addr), 32'h0000);
      chk("rmid.first_rd", 32'(mem_rd), 32'd1);
      en = 1'b0;
      wait_valid(20, n);
      chk("endrop.latency", 32'(n), 32'd2);
      chk("endrop.operand", 32'(ir_operand), 32'h0077);
      ir_ready = 1'b1;
      step();
      chk("endrop.valid", 32'(ir_valid), 32'd0);
      chk("endrop.idle_rd", 32'(mem_rd), 32'd0);
      step();
      chk("endrop.still_idle", 32'(mem_rd), 32'd0);
      chk("endrop.pc", 32'(pc_out), 32'h0002);
      $display("reset mid-fetch and en drop: pc=%h", pc_out);

      // ---- randomized run against the table model
      reset = 1'b1; ir_ready = 1'b0;
      step();
      reset = 1'b0;
      mpc = 16'h0000;
      acc_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         if (ir_valid) begin
            check_instr("rnd", mpc);
            chk("rnd.pc_out", 32'(pc_out), 32'(16'(mpc + 16'(ref_len(mem[mpc])))));
         end
         en            = ($urandom_range(0, 3) != 0);
         mem_rdy       = ($urandom_range(0, 3) != 0);
         ir_ready      = ($urandom_range(0, 1) != 0);
         pc_load       = ($urandom_range(0, 99) < 2);
         pc_load_value = 16'($urandom);
         if (ir_valid && ir_ready) begin
            $display("rnd accept: pc=%h opcode=%h operand=%h len=%0d", ir_pc, ir_opcode, ir_operand, ir_len);
            mpc = mpc + 16'(ref_len(mem[mpc]));
            acc_cnt++;
         end
         if (pc_load) mpc = pc_load_value;
         step();
      end
      pc_load = 1'b0;
      chk("rnd.accept_count", 32'(acc_cnt >= 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the 6502 core, directly upstream of the control unit. Owns the program counter and drives the memory address bus. Fetches the opcode plus 0–2 operand bytes, then presents one assembled instruction (opcode, operand, length, addressing mode) to the control unit over a valid/ready handshake. Branch and jump targets from the control unit reload the PC and flush any fetch in flight.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  reset, asynchronous, active-high.
en  input  1  fetch enable; while low, no new instruction fetch starts.
pc_load  input  1  one-cycle strobe from the control unit: reload PC and flush.
pc_load_value  input  16  new PC when pc_load=1.
mem_addr  output  16  address bus; equals pc while mem_rd=1.
mem_rd  output  1  read request.
mem_rdata  input  8  read data; valid in any cycle where mem_rd=1 and mem_rdy=1.
mem_rdy  input  1  memory ready; 0 inserts a wait state.
ir_valid  output  1  assembled instruction available.
ir_ready  input  1  control unit accepts the instruction.
ir_opcode  output  8  opcode byte.
ir_operand  output  16  {hi, lo}; unused bytes read as 0.
ir_len  output  2  instruction length, 1..3.
ir_addr_mode  output  4  addressing mode code (package enum).
ir_illegal  output  1  opcode not in the documented 6502 set.
ir_pc  output  16  address of the opcode byte.
pc_out  output  16  current PC.

Behaviour:
- Reset (async) values: pc=RESET_PC, state=IDLE, mem_rd=0, ir_valid=0, ir_opcode=0, ir_operand=0, ir_len=1, ir_addr_mode=IMP, ir_illegal=0, ir_pc=RESET_PC. Reset asserted mid-fetch discards all partial state.
- FSM states: IDLE, OP, LO, HI, HOLD.
  - IDLE: mem_rd=0. If en=1, go to OP next cycle.
  - OP: mem_rd=1, mem_addr=pc. On an edge with mem_rdy=1: capture the opcode, latch ir_pc=pc, pc+=1. Go to LO if len≥2, else HOLD.
  - LO: on mem_rdy=1 capture the low byte, pc+=1. Go to HI if len=3, else HOLD.
  - HI: on mem_rdy=1 capture the high byte, pc+=1, go to HOLD.
  - mem_rdy=0 in OP/LO/HI: stay in the state, hold mem_addr, leave pc unchanged.
- Length and mode come from the opcode_length_decoder applied to the captured opcode, registered at opcode capture.
- ir_valid is registered. It rises on the edge that enters HOLD and stays high until the cycle where ir_valid & ir_ready.
- ir_* outputs are stable while ir_valid=1.
- HOLD exit on accept: go to OP if en=1 (back-to-back, no bubble), else IDLE.
- Latency: with mem_rdy tied to 1, an N-byte instruction shows ir_valid N cycles after entering OP.
- PC arithmetic: 16-bit modulo; FFFF+1 wraps to 0000, with operand bytes fetched across the wrap.
- pc_load has priority over every other event in any state:
  - pc<=pc_load_value, ir_valid<=0, any partial fetch is discarded.
  - Next state is OP if en=1, else IDLE.
  - The memory beat completing in the same cycle is ignored.
- pc_load coinciding with an accept (ir_valid & ir_ready): the accept is honoured, then the load applies.
- en deasserted mid-fetch: the current instruction completes to HOLD; only the next fetch is suppressed.
- Illegal opcodes: len=1, mode=IMP, ir_illegal=1, handed off normally.

Decomposition:
- Shared package cpu6502_pkg holds:
  - addressing-mode enum: IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL;
  - fetch FSM state encodings;
  - RESET_PC default.
- Sub-module opcode_length_decoder (combinational). Input: opcode. Outputs: mode, len, illegal. Decode uses the aaa/bbb/cc fields, with these exceptions:
  - 0x20 JSR → ABS, len 3.
  - 0x6C → IND, len 3.
  - 0x96/0xB6 → ZPY.
  - 0xBE → ABSY.
  - bbb=100 with cc=00 (branches) → REL, len 2.
  - 0x00 BRK → IMP, len 2.
  - 0x40/0x60 → IMP, len 1.
- Length rule: IMP/ACC=1; IMM/ZP*/IND X/Y/REL=2; ABS*/IND=3.

Test Plan:
- Memory 0000: A9 42, mem_rdy=1, reset released, en=1 → ir_valid rises 2 cycles after entering OP; opcode=A9, operand=0042, len=2, mode=IMM, ir_pc=0000, pc_out=0002.
- 4C 34 12 at 0000, then EA, with ir_ready=1 → first instr len=3, operand=1234, mode=ABS; EA (len 1, IMP) valid with no idle bubble; pc=0004.
- Same LDA with mem_rdy low for 2 cycles in LO → mem_addr held at 0001, pc not advanced, ir_valid delayed exactly 2 cycles.
- ir_ready=0 for 5 cycles → ir_* stable, mem_rd=0 throughout HOLD; fetch resumes at pc on the cycle after accept.
- pc_load=1 with value 8000 during HI of 8D xx xx → no ir_valid for that instruction; next mem_addr=8000.
- Opcode AD at FFFE → operand bytes read from FFFF and 0000; pc wraps to 0001.
- Reset asserted during LO → all outputs return to reset values immediately; first fetch after release at RESET_PC.
- Opcode 02 → len=1, ir_illegal=1, pc advances by 1.
